// File: rtl/vga_pkg.sv
// Shared VGA constants and the framebuffer fetch FSM state type.
package vga_pkg;

  localparam int HFP    = 40;
  localparam int HPULSE = 48;
  localparam int HBP    = 40;
  localparam int VFP    = 13;
  localparam int VPULSE = 3;
  localparam int VBP    = 29;

  localparam int BYTES_PER_PIXEL = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CREDIT,
    REQ,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/vga_fetch_ctrl_if.sv
// Burst read request channel between the fetch scheduler and the memory read master.
interface vga_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_valid
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_valid
  );

endinterface

// File: rtl/vga_fetch_ctrl_credit.sv
// Tracks words requested but not yet returned and decides whether another burst
// still fits in the pixel FIFO.
module fetch_credit #(
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                             pixel_clk,
  input  logic                             pixel_rst,
  input  logic                             ack_i,
  input  logic                             valid_i,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_i,
  output logic                             can_issue_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(FIFO_DEPTH + BURST + 1);
  localparam int SUM_W = ((LVL_W > OUT_W) ? LVL_W : OUT_W) + 2;

  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [SUM_W-1:0] need;
  logic             can_issue_q, can_issue_d;

  // The check looks at the post-update count, so a burst acked this cycle is
  // already charged when the FSM next considers issuing.
  always_comb begin
    outstanding_d = outstanding_q;
    if (ack_i) begin
      outstanding_d = outstanding_q + OUT_W'(BURST);
    end
    if (valid_i && (outstanding_q != '0)) begin
      outstanding_d = outstanding_d - OUT_W'(1);
    end
    need        = SUM_W'(fifo_level_i) + SUM_W'(outstanding_d) + SUM_W'(BURST);
    can_issue_d = (need <= SUM_W'(FIFO_DEPTH));
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst) begin
    if (!pixel_rst) begin
      outstanding_q <= '0;
      can_issue_q   <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      can_issue_q   <= can_issue_d;
    end
  end

  assign can_issue_o = can_issue_q;

endmodule

// File: rtl/vga_fetch_ctrl.sv
// Framebuffer read scheduler: walks the frame in fixed bursts, gated by FIFO credit.
// Optional late-frame detection and counting is built when VGA_FETCH_ERR_EN is defined.
module vga_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 32
) (
  input  logic                            pixel_clk,
  input  logic                            pixel_rst,
  input  logic                            enable_i,
  input  logic [ADDR_W-1:0]               fb_base_i,
  input  logic                            frame_start_i,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_i,
  vga_fetch_ctrl_if.master                mem,
  output logic                            frame_busy_o,
`ifdef VGA_FETCH_ERR_EN
  output logic [15:0]                     err_cnt_o,
`endif
  output logic                            err_late_o
);

  localparam int TOTAL = HDISP * VDISP / BURST;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST * BYTES_PER_PIXEL);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pend_base_q, pend_base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              restart_q, restart_d;
  logic              rd_req_q, rd_req_d;
  logic              busy_q, busy_d;
  logic              fs_acc;
  logic              ack;
  logic              can_issue;

  assign fs_acc = frame_start_i && enable_i;
  assign ack    = rd_req_q && mem.rd_ack;

  fetch_credit #(
    .BURST      (BURST),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_credit (
    .pixel_clk    (pixel_clk),
    .pixel_rst    (pixel_rst),
    .ack_i        (ack),
    .valid_i      (mem.rd_valid),
    .fifo_level_i (fifo_level_i),
    .can_issue_o  (can_issue)
  );

  always_ff @(posedge pixel_clk or negedge pixel_rst) begin
    if (!pixel_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pend_base_q <= '0;
      cnt_q       <= '0;
      restart_q   <= 1'b0;
      rd_req_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_base_q <= pend_base_d;
      cnt_q       <= cnt_d;
      restart_q   <= restart_d;
      rd_req_q    <= rd_req_d;
      busy_q      <= busy_d;
    end
  end

  // A late frame_start in REQ is parked in restart_q so the open handshake
  // finishes at its original address before the walk restarts.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_base_d = pend_base_q;
    cnt_d       = cnt_q;
    restart_d   = restart_q;
    case (state_q)
      IDLE, DONE: begin
        if (fs_acc) begin
          state_d = WAIT_CREDIT;
          addr_d  = fb_base_i;
          cnt_d   = CNT_W'(TOTAL);
        end
      end
      WAIT_CREDIT: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (fs_acc) begin
          addr_d = fb_base_i;
          cnt_d  = CNT_W'(TOTAL);
        end else if (can_issue) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (fs_acc) begin
          restart_d   = 1'b1;
          pend_base_d = fb_base_i;
        end
        if (ack) begin
          restart_d = 1'b0;
          if (fs_acc || restart_q) begin
            addr_d  = fs_acc ? fb_base_i : pend_base_q;
            cnt_d   = CNT_W'(TOTAL);
            state_d = enable_i ? WAIT_CREDIT : IDLE;
          end else begin
            addr_d = addr_q + STEP;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = DONE;
            end else begin
              state_d = enable_i ? WAIT_CREDIT : IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_req_d = (state_d == REQ);
    busy_d   = (state_d == WAIT_CREDIT) || (state_d == REQ);
  end

  assign mem.rd_req   = rd_req_q;
  assign mem.rd_addr  = addr_q;
  assign frame_busy_o = busy_q;

`ifdef VGA_FETCH_ERR_EN
  logic        late;
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  assign late = fs_acc && busy_q;

  always_comb begin
    err_d     = err_q || late;
    err_cnt_d = err_cnt_q;
    if (late && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst) begin
    if (!pixel_rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_late_o = err_q;
  assign err_cnt_o  = err_cnt_q;
`else
  assign err_late_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Scoreboard bench for vga_fetch_ctrl: expected burst addresses are queued when a
// frame is started and popped as the bench-side memory responder acks each request.
module tb_vga_fetch_ctrl;

  localparam int HDISP      = 8;
  localparam int VDISP      = 4;
  localparam int BURST      = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 32;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
  localparam int BURSTS     = HDISP * VDISP / BURST;
  localparam int STEP       = BURST * 4;
`ifdef VGA_FETCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              pixel_clk = 1'b0;
  logic              pixel_rst = 1'b0;
  logic              enable_i;
  logic [ADDR_W-1:0] fb_base_i;
  logic              frame_start_i;
  logic [LVL_W-1:0]  fifo_level_i;
  logic              frame_busy_o;
  logic              err_late_o;
`ifdef VGA_FETCH_ERR_EN
  logic [15:0]       err_cnt_o;
`endif

  vga_fetch_ctrl_if #(.ADDR_W(ADDR_W)) mem ();

  vga_fetch_ctrl #(
    .HDISP      (HDISP),
    .VDISP      (VDISP),
    .BURST      (BURST),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .pixel_clk     (pixel_clk),
    .pixel_rst     (pixel_rst),
    .enable_i      (enable_i),
    .fb_base_i     (fb_base_i),
    .frame_start_i (frame_start_i),
    .fifo_level_i  (fifo_level_i),
    .mem           (mem),
    .frame_busy_o  (frame_busy_o),
`ifdef VGA_FETCH_ERR_EN
    .err_cnt_o     (err_cnt_o),
`endif
    .err_late_o    (err_late_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] expQ[$];
  bit          autoAck = 1'b1;
  bit          autoValid = 1'b1;
  int          ackDelay = 1;
  int          waitCnt = 0;
  int          pendingWords = 0;
  int          reqRises = 0;
  int          acks = 0;
  logic        prevReq = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Ack the visible request and check its address against the scoreboard head.
  task automatic driveAck();
    logic [63:0] expAddr;
    expAddr = {64{1'b1}};
    if (expQ.size() != 0) expAddr = 64'(expQ.pop_front());
    checkOutput("req_addr", 64'(mem.rd_addr), expAddr);
    mem.rd_ack = 1'b1;
    acks++;
    waitCnt = 0;
  endtask

  task automatic stepCycle();
    @(posedge pixel_clk);
    #1;
    if (mem.rd_req && !prevReq) reqRises++;
    prevReq = mem.rd_req;
    if (mem.rd_ack) begin
      mem.rd_ack = 1'b0;
      pendingWords += BURST;
    end else if (autoAck && mem.rd_req) begin
      waitCnt++;
      if (waitCnt > ackDelay) driveAck();
    end
    if (autoValid && pendingWords > 0) begin
      mem.rd_valid = 1'b1;
      pendingWords--;
    end else begin
      mem.rd_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] base, input bit expectFrame);
    if (expectFrame) begin
      for (int i = 0; i < BURSTS; i++) expQ.push_back(base + 32'(i * STEP));
    end
    fb_base_i     = base;
    frame_start_i = 1'b1;
    stepCycle();
    frame_start_i = 1'b0;
  endtask

  task automatic waitReq(input string tag, input int maxCycles, output int cycles);
    cycles = 0;
    while (!mem.rd_req && cycles < maxCycles) begin
      stepCycle();
      cycles++;
    end
    if (!mem.rd_req) checkOutput(tag, 64'(mem.rd_req), 64'd1);
  endtask

  task automatic waitBusyLow(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (frame_busy_o && n < maxCycles) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 64'(frame_busy_o), 64'd0);
  endtask

  initial begin
    int cyc;
    int base;
    logic [31:0] front;

    enable_i      = 1'b1;
    fb_base_i     = '0;
    frame_start_i = 1'b0;
    fifo_level_i  = '0;
    mem.rd_ack    = 1'b0;
    mem.rd_valid  = 1'b0;

    repeat (3) stepCycle();
    checkOutput("rst_rd_req", 64'(mem.rd_req), 64'd0);
    checkOutput("rst_rd_addr", 64'(mem.rd_addr), 64'd0);
    checkOutput("rst_busy", 64'(frame_busy_o), 64'd0);
    checkOutput("rst_err_late", 64'(err_late_o), 64'd0);
    checkOutput("rst_outstanding", 64'(dut.u_credit.outstanding_q), 64'd0);
    pixel_rst = 1'b1;
    repeat (2) stepCycle();

    $display("[TB] basic frame");
    base = acks;
    applyStimulus(32'h1000, 1'b1);
    checkOutput("basic_n1_req", 64'(mem.rd_req), 64'd0);
    checkOutput("basic_n1_busy", 64'(frame_busy_o), 64'd1);
    stepCycle();
    checkOutput("basic_n2_req", 64'(mem.rd_req), 64'd1);
    waitBusyLow("basic_done", 300);
    checkOutput("basic_req_count", 64'(acks - base), 64'(BURSTS));
    checkOutput("basic_queue_empty", 64'(expQ.size()), 64'd0);
    repeat (10) stepCycle();

    $display("[TB] credit stall");
    autoValid    = 1'b0;
    fifo_level_i = LVL_W'(5);
    stepCycle();
    base = reqRises;
    applyStimulus(32'h2000, 1'b1);
    repeat (6) stepCycle();
    checkOutput("stall_no_req", 64'(reqRises - base), 64'd0);
    fifo_level_i = LVL_W'(4);
    stepCycle();
    checkOutput("stall_drop_c1", 64'(mem.rd_req), 64'd0);
    stepCycle();
    checkOutput("stall_drop_c2", 64'(mem.rd_req), 64'd1);
    stepCycle();
    stepCycle();
    base = reqRises;
    repeat (6) stepCycle();
    checkOutput("stall_hold", 64'(reqRises - base), 64'd0);
    autoValid = 1'b1;
    waitReq("stall_release_timeout", 20, cyc);
    checkOutput("stall_release_lat", 64'(cyc), 64'd6);
    fifo_level_i = '0;
    waitBusyLow("stall_done", 300);
    checkOutput("stall_queue_empty", 64'(expQ.size()), 64'd0);
    repeat (10) stepCycle();

    $display("[TB] simultaneous ack and valid");
    autoAck   = 1'b0;
    autoValid = 1'b0;
    applyStimulus(32'h6000, 1'b1);
    waitReq("av_req1_timeout", 20, cyc);
    driveAck();
    stepCycle();
    checkOutput("av_out_pre", 64'(dut.u_credit.outstanding_q), 64'd4);
    waitReq("av_req2_timeout", 20, cyc);
    driveAck();
    mem.rd_valid = 1'b1;
    stepCycle();
    checkOutput("av_out_post", 64'(dut.u_credit.outstanding_q), 64'd7);
    pendingWords = 7;
    autoAck      = 1'b1;
    autoValid    = 1'b1;
    waitBusyLow("av_done", 300);
    checkOutput("av_queue_empty", 64'(expQ.size()), 64'd0);
    repeat (10) stepCycle();

    $display("[TB] late frame");
    autoAck = 1'b0;
    applyStimulus(32'h8000, 1'b1);
    waitReq("late_req_timeout", 20, cyc);
    front = expQ[0];
    expQ.delete();
    expQ.push_back(front);
    applyStimulus(32'h9000, 1'b1);
    checkOutput("late_err_flag", 64'(err_late_o), 64'(ERR_EN));
`ifdef VGA_FETCH_ERR_EN
    checkOutput("late_err_cnt", 64'(err_cnt_o), 64'd1);
`endif
    for (int i = 0; i < 3; i++) begin
      if (i > 0) stepCycle();
      checkOutput("late_hold_req", 64'(mem.rd_req), 64'd1);
      checkOutput("late_hold_addr", 64'(mem.rd_addr), 64'h8000);
    end
    driveAck();
    autoAck = 1'b1;
    stepCycle();
    checkOutput("late_new_base", 64'(mem.rd_addr), 64'h9000);
    waitBusyLow("late_done", 300);
    checkOutput("late_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("late_err_sticky", 64'(err_late_o), 64'(ERR_EN));
    repeat (10) stepCycle();

    $display("[TB] disable mid-frame");
    fifo_level_i = LVL_W'(5);
    stepCycle();
    base = reqRises;
    applyStimulus(32'hA000, 1'b0);
    repeat (3) stepCycle();
    checkOutput("dis_busy_before", 64'(frame_busy_o), 64'd1);
    enable_i = 1'b0;
    stepCycle();
    checkOutput("dis_busy_after", 64'(frame_busy_o), 64'd0);
    applyStimulus(32'hB000, 1'b0);
    fifo_level_i = '0;
    repeat (8) stepCycle();
    checkOutput("dis_no_req", 64'(reqRises - base), 64'd0);
    checkOutput("dis_fs_ignored", 64'(frame_busy_o), 64'd0);
    enable_i = 1'b1;
    stepCycle();

    $display("[TB] reset mid-request");
    autoAck   = 1'b0;
    autoValid = 1'b0;
    applyStimulus(32'hC000, 1'b1);
    waitReq("rstm_req1_timeout", 20, cyc);
    driveAck();
    stepCycle();
    waitReq("rstm_req2_timeout", 20, cyc);
    checkOutput("rstm_req_before", 64'(mem.rd_req), 64'd1);
    #2;
    pixel_rst = 1'b0;
    #1;
    checkOutput("rstm_rd_req", 64'(mem.rd_req), 64'd0);
    checkOutput("rstm_busy", 64'(frame_busy_o), 64'd0);
    checkOutput("rstm_outstanding", 64'(dut.u_credit.outstanding_q), 64'd0);
    checkOutput("rstm_err_late", 64'(err_late_o), 64'd0);
    expQ.delete();
    pendingWords = 0;
    mem.rd_ack   = 1'b0;
    stepCycle();
    pixel_rst = 1'b1;
    repeat (2) stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
